// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory boot loader, its memory and its bench.
package imem_pkg;

    localparam int          IMEM_DEPTH    = 32;
    localparam int          IMEM_IDX_W    = 5;
    localparam int          IMEM_BASE_IDX = 1;
    localparam logic [31:0] NOP_WORD      = 32'h0;

    typedef enum logic [2:0] {
        WAIT_LEN,
        LOAD,
        CLEAR,
        RUN,
        ERROR
    } imem_state_e;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core, loads a length-prefixed program from the host into
// instruction memory, zero-fills the rest, then releases the core and passes its PC through.
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int DEPTH    = IMEM_DEPTH,
    parameter int IDX_W    = IMEM_IDX_W,
    parameter int BASE_IDX = IMEM_BASE_IDX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_valid,
    input  logic [31:0] host_data,
    output logic        host_ready,
    input  logic        load_req,
    input  logic [31:0] pc_addr,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err,
    output imem_state_e state_dbg
);

    // Index counters carry one extra bit so that DEPTH itself is representable.
    localparam int CW = IDX_W + 1;

    imem_state_e   state_q, state_d;
    logic [CW-1:0] widx_q, widx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          host_ready_q, host_ready_d;
    logic          we_q, we_d;
    logic [31:0]   waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          load_done_q, load_done_d;
    logic          hs;

    // Host handshake: a word transfers on a rising edge where host_valid and host_ready are
    // both 1; host_ready is registered and never depends on host_valid in the same cycle.
    assign hs = host_valid && host_ready_q;

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        case (state_q)
            WAIT_LEN: begin
                if (hs) begin
                    widx_d = CW'(BASE_IDX);
                    if (host_data == 32'd0) begin
                        state_d = CLEAR;
                    end else if (host_data > 32'(DEPTH - BASE_IDX)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = host_data[CW-1:0];
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = {{(30-IDX_W){1'b0}}, widx_q[IDX_W-1:0], 2'b00};
                    wdata_d = host_data;
                    widx_d  = widx_q + CW'(1);
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                // The cycle that finds widx at DEPTH shows the final registered write and issues none.
                if (widx_q == CW'(DEPTH)) begin
                    state_d = RUN;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = {{(30-IDX_W){1'b0}}, widx_q[IDX_W-1:0], 2'b00};
                    wdata_d = NOP_WORD;
                    widx_d  = widx_q + CW'(1);
                end
            end
            RUN: begin
                if (load_req) begin
                    state_d = WAIT_LEN;
                end
            end
            ERROR: begin
                if (load_req) begin
                    state_d = WAIT_LEN;
                end
            end
            default: begin
                state_d = WAIT_LEN;
            end
        endcase
        host_ready_d = (state_d == state_q) && ((state_q == WAIT_LEN) || (state_q == LOAD));
        load_done_d  = (state_d == RUN) && (state_q != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_LEN;
            widx_q       <= '0;
            cnt_q        <= '0;
            host_ready_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            cnt_q        <= cnt_d;
            host_ready_q <= host_ready_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            load_done_q  <= load_done_d;
        end
    end

    assign host_ready = host_ready_q;
    assign imem_we    = we_q;
    assign imem_wdata = wdata_q;
    assign imem_addr  = (state_q == RUN) ? pc_addr : waddr_q;
    assign core_hold  = (state_q != RUN);
    assign load_done  = load_done_q;
    assign load_err   = (state_q == ERROR);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: random program loads against a queue of expected memory writes.
module tb_imem_boot_loader;
    import imem_pkg::*;

    logic        clk;
    logic        reset;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_ready;
    logic        load_req;
    logic [31:0] pc_addr;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;
    imem_state_e state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    logic [31:0] mem [IMEM_DEPTH];
    logic [31:0] ref_mem [IMEM_DEPTH];

    imem_boot_loader dut (
        .clk        (clk),
        .reset      (reset),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .load_req   (load_req),
        .pc_addr    (pc_addr),
        .imem_addr  (imem_addr),
        .imem_we    (imem_we),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory stand-in.
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[IMEM_IDX_W+1:2]] <= imem_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_addr(input int idx);
        return 32'(idx) << 2;
    endfunction

    // Monitor: every write must be the next expected one; in RUN the memory follows the PC.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_addr, imem_wdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("write", {imem_addr, imem_wdata}, exp_e);
                end
            end
            if (!core_hold) begin
                chk("run_we", 64'(imem_we), 64'd0);
                chk("run_addr", 64'(imem_addr), 64'(pc_addr));
            end
        end
    end

    task automatic send_word(input logic [31:0] d);
        int t = 0;
        host_valid = 1'b1;
        host_data  = d;
        while (!host_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("host_ready_timeout", 64'(t < 100), 64'd1);
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic wait_run(input bit pulse_req);
        int t = 0;
        while (!load_done && t < 100) begin
            chk("hold_before_run", 64'(core_hold), 64'd1);
            load_req = pulse_req && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            t++;
        end
        load_req = 1'b0;
        chk("load_done_seen", 64'(load_done), 64'd1);
        chk("hold_falls_with_done", 64'(core_hold), 64'd0);
        chk("state_run", 64'(state_dbg), 64'(RUN));
        @(negedge clk);
        chk("load_done_width", 64'(load_done), 64'd0);
        chk("hold_stays_low", 64'(core_hold), 64'd0);
    endtask

    task automatic check_mem();
        for (int i = IMEM_BASE_IDX; i < IMEM_DEPTH; i++) begin
            chk($sformatf("mem[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));
        end
    endtask

    // Reference model: program occupies BASE.. upward, everything above it becomes NOP_WORD.
    task automatic do_load(input int n, input int gmin, input int gmax, input bit pulse_req);
        logic [31:0] words[$];
        words = {};
        for (int k = 0; k < n; k++) words.push_back($urandom);
        for (int i = IMEM_BASE_IDX; i < IMEM_DEPTH; i++) begin
            ref_mem[i] = (i - IMEM_BASE_IDX < n) ? words[i - IMEM_BASE_IDX] : NOP_WORD;
            exp_q.push_back({word_addr(i), ref_mem[i]});
        end
        send_word(32'(n));
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(gmin, gmax)) @(negedge clk);
            load_req = pulse_req && ($urandom_range(0, 1) == 1);
            send_word(words[k]);
            load_req = 1'b0;
        end
        wait_run(pulse_req);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check_mem();
    endtask

    task automatic req_reload();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("hold_after_req", 64'(core_hold), 64'd1);
        chk("state_wait_len", 64'(state_dbg), 64'(WAIT_LEN));
        chk("err_after_req", 64'(load_err), 64'd0);
    endtask

    task automatic expect_error(input logic [31:0] n);
        send_word(n);
        repeat (2) @(negedge clk);
        chk("err_state", 64'(state_dbg), 64'(ERROR));
        chk("err_flag", 64'(load_err), 64'd1);
        chk("err_hold", 64'(core_hold), 64'd1);
        chk("err_ready", 64'(host_ready), 64'd0);
        chk("err_no_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w1, w2;
        reset      = 1'b1;
        host_valid = 1'b0;
        host_data  = '0;
        load_req   = 1'b0;
        pc_addr    = '0;
        for (int i = 0; i < IMEM_DEPTH; i++) ref_mem[i] = '0;
        @(negedge clk);
        chk("rst_ready", 64'(host_ready), 64'd0);
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_hold", 64'(core_hold), 64'd1);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_err", 64'(load_err), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'(WAIT_LEN));
        @(negedge clk);
        reset = 1'b0;

        // Short program, words back to back.
        do_load(3, 0, 0, 1'b0);

        // Program fills memory, host_valid every other cycle; then PC pass-through.
        req_reload();
        do_load(31, 1, 1, 1'b0);
        pc_addr = 32'h40;
        #1;
        chk("pc_pass_0x40", 64'(imem_addr), 64'h40);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pc_addr = $urandom;
            #1;
            chk("pc_pass_rand", 64'(imem_addr), 64'(pc_addr));
        end

        // Oversized length, recovery, then an empty program.
        req_reload();
        expect_error(32'd32);
        req_reload();
        do_load(0, 0, 0, 1'b0);

        // Reload request with a host word in the same cycle: word must be dropped.
        @(negedge clk);
        load_req   = 1'b1;
        host_valid = 1'b1;
        host_data  = 32'd5;
        @(negedge clk);
        load_req   = 1'b0;
        host_valid = 1'b0;
        chk("req_hold_next", 64'(core_hold), 64'd1);
        chk("req_ready_next", 64'(host_ready), 64'd0);
        do_load(2, 0, 0, 1'b0);

        // Reset after two of five words.
        req_reload();
        w1 = $urandom;
        w2 = $urandom;
        exp_q.push_back({word_addr(IMEM_BASE_IDX), w1});
        exp_q.push_back({word_addr(IMEM_BASE_IDX + 1), w2});
        send_word(32'd5);
        send_word(w1);
        send_word(w2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ready", 64'(host_ready), 64'd0);
        chk("mid_rst_we", 64'(imem_we), 64'd0);
        chk("mid_rst_wdata", 64'(imem_wdata), 64'd0);
        chk("mid_rst_addr", 64'(imem_addr), 64'd0);
        chk("mid_rst_hold", 64'(core_hold), 64'd1);
        chk("mid_rst_state", 64'(state_dbg), 64'(WAIT_LEN));
        chk("mid_rst_partial", 64'(exp_q.size()), 64'd0);
        chk("mid_rst_mem1", 64'(mem[IMEM_BASE_IDX]), 64'(w1));
        chk("mid_rst_mem2", 64'(mem[IMEM_BASE_IDX + 1]), 64'(w2));
        do_load(3, 0, 0, 1'b0);

        // Reload requests during LOAD and CLEAR are ignored.
        req_reload();
        do_load(3, 0, 1, 1'b1);

        // Random programs and random illegal lengths.
        for (int r = 0; r < 4; r++) begin
            req_reload();
            do_load(int'($urandom_range(1, 31)), 0, 2, r[0]);
        end
        req_reload();
        expect_error(32'h8000_0000);
        req_reload();
        expect_error($urandom_range(32'd33, 32'hFFFF_FFFF));
        req_reload();
        do_load(int'($urandom_range(1, 31)), 0, 1, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
